// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Per-button input conditioner. Each channel synchronises its raw pin to clk,
// debounces it, and produces a stable level plus registered one-cycle press,
// release and (optionally) auto-repeat pulses. Every channel is independent.
//
// Parameters
//   N_BTN   : number of button channels
//   DB_CYC  : debounce window in clk cycles (>= 1)
//   REP_DLY : cycles from o_press to the first o_repeat (>= 1)
//   REP_PER : cycles between subsequent o_repeat pulses (>= 1)
//   REP_EN  : per-channel auto-repeat enable mask
//
// Ports
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   i_btn     : raw asynchronous active-high button pins
//   o_level   : debounced stable level
//   o_press   : one-cycle pulse on debounced 0->1
//   o_release : one-cycle pulse on debounced 1->0
//   o_repeat  : one-cycle auto-repeat pulse while held (enabled channels only)
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int               N_BTN   = 4,
    parameter int               DB_CYC  = 500_000,
    parameter int               REP_DLY = 12_500_000,
    parameter int               REP_PER = 2_500_000,
    parameter logic [N_BTN-1:0] REP_EN  = {N_BTN{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_repeat
);

    localparam int DB_W     = $clog2(DB_CYC + 1);
    localparam int HOLD_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(REP_DLY - 1);
    localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REP_PER - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DLY,
        HOLD_REP
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch

        logic              s1;
        logic              s2;
        logic [DB_W-1:0]   db_cnt;
        logic              level;
        logic              db_done;
        logic              press_ev;
        logic              release_ev;
        logic              press_q;
        logic              release_q;
        logic              repeat_q;
        state_t            state;
        state_t            state_nxt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_nxt;
        logic              rep_nxt;

        // ---- stage: two-flop synchroniser ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= i_btn[i];
                s2 <= s1;
            end
        end

        // The window completes on the cycle where the disagreement has
        // persisted for DB_CYC consecutive cycles; that same edge flips the
        // level and raises the matching edge pulse.
        assign db_done    = (s2 != level) && (db_cnt == DB_LAST);
        assign press_ev   = db_done && !level;
        assign release_ev = db_done && level;

        // ---- stage: debounce counter, level and edge pulses ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt    <= '0;
                level     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= press_ev;
                release_q <= release_ev;
                if (s2 == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    level  <= ~level;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // ---- stage: hold/repeat state register ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= IDLE;
                hold_cnt <= '0;
                repeat_q <= 1'b0;
            end else begin
                state    <= state_nxt;
                hold_cnt <= hold_nxt;
                repeat_q <= rep_nxt;
            end
        end

        // Release is tested before any repeat condition so a release landing
        // on a repeat boundary suppresses that repeat.
        always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            rep_nxt   = 1'b0;
            case (state)
                IDLE: begin
                    if (press_ev) begin
                        state_nxt = HOLD_DLY;
                        hold_nxt  = '0;
                    end
                end
                HOLD_DLY: begin
                    if (release_ev) begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end else if (hold_cnt == DLY_LAST) begin
                        // Without repeat enabled the counter parks here.
                        if (REP_EN[i]) begin
                            rep_nxt   = 1'b1;
                            hold_nxt  = '0;
                            state_nxt = HOLD_REP;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                HOLD_REP: begin
                    if (release_ev) begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end else if (hold_cnt == PER_LAST) begin
                        rep_nxt  = 1'b1;
                        hold_nxt = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end

        assign o_level[i]   = level;
        assign o_press[i]   = press_q;
        assign o_release[i] = release_q;
        assign o_repeat[i]  = repeat_q;

    end : g_ch

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed bench for btn_conditioner with DB_CYC=4, REP_DLY=10, REP_PER=3,
// REP_EN=4'b0001. Expected latencies are hand-derived: an input change first
// sampled at edge k shows on o_level / edge pulses at edge k+5.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int N_BTN   = 4;
    localparam int DB_CYC  = 4;
    localparam int REP_DLY = 10;
    localparam int REP_PER = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_BTN-1:0] i_btn;
    logic [N_BTN-1:0] o_level;
    logic [N_BTN-1:0] o_press;
    logic [N_BTN-1:0] o_release;
    logic [N_BTN-1:0] o_repeat;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .N_BTN  (N_BTN),
        .DB_CYC (DB_CYC),
        .REP_DLY(REP_DLY),
        .REP_PER(REP_PER),
        .REP_EN (4'b0001)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_repeat (o_repeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          pat [8];
        int          npress;
        int          nrel;
        int          nrep;
        int          nhigh;
        int          rel_off;
        int          first_rep;
        logic [63:0] rep_mask;

        pat = '{1, 1, 1, 0, 1, 1, 1, 0};

        // Reset with all buttons held
        rst_n = 1'b0;
        i_btn = 4'hF;
        step(3);
        check("rst_level",   64'(o_level),   64'h0);
        check("rst_press",   64'(o_press),   64'h0);
        check("rst_release", 64'(o_release), 64'h0);
        check("rst_repeat",  64'(o_repeat),  64'h0);
        rst_n = 1'b1;
        step(5);
        check("rst_level_e5", 64'(o_level), 64'h0);
        check("rst_press_e5", 64'(o_press), 64'h0);
        step(1);
        check("rst_level_e6", 64'(o_level), 64'hF);
        check("rst_press_e6", 64'(o_press), 64'hF);
        step(1);
        check("rst_press_e7", 64'(o_press), 64'h0);
        check("rst_level_e7", 64'(o_level), 64'hF);
        i_btn = 4'h0;
        step(5);
        check("rst_rel_early", 64'(o_release), 64'h0);
        step(1);
        check("rst_release_all", 64'(o_release), 64'hF);
        check("rst_level_off",   64'(o_level),   64'h0);
        check("rst_no_repeat",   64'(o_repeat),  64'h0);
        step(1);
        check("rst_release_once", 64'(o_release), 64'h0);

        // Bounce rejection on channel 1
        for (int j = 0; j < 8; j++) begin
            i_btn[1] = pat[j][0];
            step(1);
            check("bnc_level", 64'(o_level), 64'h0);
            check("bnc_press", 64'(o_press), 64'h0);
        end
        i_btn[1] = 1'b1;
        step(5);
        check("bnc_press_e4", 64'(o_press), 64'h0);
        step(1);
        check("bnc_press_e5", 64'(o_press), 64'h2);
        check("bnc_level_e5", 64'(o_level), 64'h2);
        i_btn[1] = 1'b0;
        step(6);
        check("bnc_release", 64'(o_release), 64'h2);
        step(1);

        // Clean press/release on channel 2 (repeat disabled)
        npress = 0; nrel = 0; nrep = 0; nhigh = 0;
        i_btn[2] = 1'b1;
        for (int j = 0; j < 42; j++) begin
            if (j == 30) i_btn[2] = 1'b0;
            step(1);
            npress += int'(o_press[2]);
            nrel   += int'(o_release[2]);
            nrep   += int'(o_repeat[2]);
            nhigh  += int'(o_level[2]);
        end
        check("clean_npress", 64'(npress), 64'd1);
        check("clean_nrel",   64'(nrel),   64'd1);
        check("clean_nrep",   64'(nrep),   64'd0);
        check("clean_nhigh",  64'(nhigh),  64'd30);

        // Auto-repeat on channel 0, released so the release lands on offset 34
        i_btn[0] = 1'b1;
        step(6);
        check("ar_press", 64'(o_press), 64'h1);
        rep_mask = '0;
        rel_off  = -1;
        npress   = 0;
        for (int off = 1; off <= 40; off++) begin
            if (off == 29) i_btn[0] = 1'b0;
            step(1);
            if (o_repeat[0]) rep_mask[off] = 1'b1;
            if (o_release[0]) rel_off = off;
            npress += int'(o_press[0]);
            if (off == 34) begin
                check("bnd_release", 64'(o_release[0]), 64'h1);
                check("bnd_repeat",  64'(o_repeat[0]),  64'h0);
            end
        end
        check("ar_repeat_mask", rep_mask,        64'h0000_0000_9249_2400);
        check("ar_release_off", 64'(rel_off),    64'd34);
        check("ar_no_repress",  64'(npress),     64'd0);

        // Independence and mid-hold asynchronous reset
        i_btn = 4'b1001;
        step(5);
        check("ind_press_e4", 64'(o_press), 64'h0);
        step(1);
        check("ind_press", 64'(o_press), 64'h9);
        step(3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_level",   64'(o_level),   64'h0);
        check("mid_rst_press",   64'(o_press),   64'h0);
        check("mid_rst_release", 64'(o_release), 64'h0);
        check("mid_rst_repeat",  64'(o_repeat),  64'h0);
        step(1);
        rst_n = 1'b1;
        step(5);
        check("re_press_e5", 64'(o_press), 64'h0);
        step(1);
        check("re_press_e6", 64'(o_press), 64'h9);
        first_rep = -1;
        nrep      = 0;
        for (int off = 1; off <= 12; off++) begin
            step(1);
            if (o_repeat[0] && first_rep < 0) first_rep = off;
            nrep += int'(o_repeat[3]);
        end
        check("re_first_repeat", 64'(first_rep), 64'd10);
        check("re_ch3_norepeat", 64'(nrep),      64'd0);
        i_btn = 4'h0;
        step(8);
        check("end_level", 64'(o_level), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Per-button input conditioner between the raw push-button pins and the control FSM's button inputs. It synchronises each button to `clk`, debounces it, and emits a stable level plus one-cycle press, release and auto-repeat pulses. The FSM therefore sees exactly one event per physical press. `btn[4]` drives the system reset and is not routed through this block. `btn[3:0]` are.

## Interface
- `N_BTN`, 4: number of independent button channels.
- `DB_CYC`, 500_000: debounce window in `clk` cycles (20 ms at 25 MHz). Must be ≥ 1.
- `REP_DLY`, 12_500_000: cycles from `o_press` to the first `o_repeat` (500 ms). Must be ≥ 1.
- `REP_PER`, 2_500_000: cycles between subsequent `o_repeat` pulses (100 ms). Must be ≥ 1.
- `REP_EN`, {N_BTN{1'b0}}: per-channel mask. Bit i = 1 enables auto-repeat on channel i.

- `clk` in 1: system clock (25 MHz divided clock).
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_btn` in N_BTN: raw, asynchronous, active-high button pins.
- `o_level` in/out: out, N_BTN, debounced stable level.
- `o_press` out N_BTN: one-cycle pulse when `o_level[i]` goes 0→1.
- `o_release` out N_BTN: one-cycle pulse when `o_level[i]` goes 1→0.
- `o_repeat` out N_BTN: one-cycle auto-repeat pulse while held (REP_EN channels only).

## Operation
- Channels are fully independent. Everything below applies per channel i.
- **Synchroniser:** two flops `s1 ← i_btn[i]`, then `s2 ← s1`. Both reset to 0.
- **Debounce counter:** `db_cnt` has width $clog2(DB_CYC+1).
  - Each cycle where `s2 == o_level[i]`: `db_cnt ← 0`.
  - Each cycle where `s2 != o_level[i]`:
    - if `db_cnt == DB_CYC-1`: `o_level[i]` toggles and `db_cnt ← 0`;
    - otherwise `db_cnt` increments.
  - Any single-cycle agreement restarts the window. Bounces shorter than `DB_CYC` consecutive cycles never change `o_level`.
- **Edge pulses:** `o_press` and `o_release` are registered. They assert on the same edge that updates `o_level`, for exactly one cycle.
- **Channel states:**
  - `IDLE`: `o_level` = 0.
  - `HOLD_DLY`: held, waiting for the first repeat.
  - `HOLD_REP`: held, repeating.
- **Transitions:**
  - `IDLE` → `HOLD_DLY` on the press edge; `hold_cnt ← 0`.
  - In `HOLD_DLY`, `hold_cnt` increments each cycle. When it equals `REP_DLY-1` and `REP_EN[i]` = 1: `o_repeat` pulses, `hold_cnt ← 0`, state → `HOLD_REP`.
  - In `HOLD_REP`: when `hold_cnt == REP_PER-1`, `o_repeat` pulses and `hold_cnt ← 0`. Otherwise `hold_cnt` increments.
  - With `REP_EN[i]` = 0, the channel stays in `HOLD_DLY` and `hold_cnt` saturates at `REP_DLY-1`. It never wraps and `o_repeat` never asserts.
  - Any state → `IDLE` on the release edge. `hold_cnt ← 0`. No `o_repeat` in the release cycle or after it.
- `hold_cnt` width is $clog2(max(REP_DLY,REP_PER)+1).
- `o_press`, `o_release` and `o_repeat` are mutually exclusive per channel in any cycle.

## Timing
- **Reset:** all flops, counters and states clear asynchronously. All outputs read 0: `o_level`, `o_press`, `o_release`, `o_repeat`.
- **Press latency:** `i_btn` rises cleanly and is first sampled by `s1` at edge k.
  - `s2` = 1 from edge k+1.
  - `o_level` and `o_press` assert at edge k+1+DB_CYC.
  - Release is symmetric.
- **First repeat:** at `REP_DLY` edges after the `o_press` edge. Following repeats every `REP_PER` edges.
- **Release at the repeat boundary:** the release edge wins. `o_repeat` is suppressed that cycle.
- **Reset while held:** after `rst_n` rises, a still-held button produces `o_press` DB_CYC+2 edges after the first edge, counting the resynchronisation.
- **Continuous bouncing:** if the input keeps changing faster than the window, `o_level` holds its last value indefinitely.

## Test plan
Parameters for all scenarios: DB_CYC=4, REP_DLY=10, REP_PER=3, N_BTN=4, REP_EN=4'b0001.

- **Reset:** assert `rst_n`=0 with `i_btn`=4'hF. → All outputs are 0 during reset. After release, `o_level`=4'hF and `o_press`=4'hF pulse together at DB_CYC+2 edges, for one cycle.
- **Bounce rejection:** toggle `i_btn[1]` as 1,1,1,0,1,1,1,0 for 8 cycles. → `o_level[1]` stays 0 and no pulses occur. Then hold at 1. → `o_press[1]` asserts at exactly 5 edges after the first sampled 1 of the stable run.
- **Clean press/release:** on channel 2, hold `i_btn` 1 for 30 cycles, then 0. → Exactly one `o_press[2]` and one `o_release[2]`. `o_level[2]` is high for 30 cycles. `o_repeat[2]` is never asserted (REP_EN bit 0).
- **Auto-repeat:** hold channel 0 for 30 cycles after `o_press[0]`. → `o_repeat[0]` at +10, +13, +16, +19, +22, +25, +28.
- **Release at the repeat boundary:** time the release so the debounced release edge coincides with a scheduled repeat. → `o_release[0]` = 1 and `o_repeat[0]` = 0 in that cycle. No further repeats.
- **Independence and mid-operation reset:** press channels 0 and 3 simultaneously. → `o_press` = 4'b1001 in one cycle. Then assert `rst_n` mid-hold. → All outputs 0 on the same cycle, asynchronously. `hold_cnt` has restarted when the repeat timing resumes after the re-press.
